// File: rtl/hc595_frame_arbiter.sv
// Round-robin arbiter for two byte requesters feeding one SN74HC595 (MSB first, then latch).
// Optional periodic re-send of the last byte is enabled by defining HC595_AUTO_REFRESH_EN.
module hc595_frame_arbiter #(
  parameter int unsigned CLK_DIV        = 6,
  parameter int unsigned REFRESH_PERIOD = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       busy,
  output logic       grant_id,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  localparam logic [15:0] DIV_LAST = (CLK_DIV == 0) ? 16'd0 : 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  last_data_q, last_data_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        ptr_q, ptr_d;
  logic        grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        ser_data_q, ser_data_d;
  logic        ser_clk_q, ser_clk_d;
  logic        ser_latch_q, ser_latch_d;
  logic        frame_done_q, frame_done_d;
  logic        is_idle, win0, win1, xfer, refresh_fire, cnt_done;

  // ptr_q holds the last-served requester; on a tie the other one wins.
  assign is_idle    = (state_q == IDLE);
  assign win0       = req0_valid & (~req1_valid | ptr_q);
  assign win1       = req1_valid & (~req0_valid | ~ptr_q);
  assign req0_ready = rst_n & is_idle & win0;
  assign req1_ready = rst_n & is_idle & win1;
  assign xfer       = req0_ready | req1_ready;
  assign cnt_done   = (cnt_q == DIV_LAST);

`ifdef HC595_AUTO_REFRESH_EN
  localparam logic [31:0] REFRESH_LAST =
    (REFRESH_PERIOD == 0) ? 32'd0 : 32'(REFRESH_PERIOD - 1);

  logic [31:0] idle_cnt_q, idle_cnt_d;

  assign refresh_fire = is_idle & ~req0_valid & ~req1_valid & (idle_cnt_q == REFRESH_LAST);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (xfer || refresh_fire) begin
      idle_cnt_d = '0;
    end else if (is_idle) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign refresh_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    last_data_d = last_data_q;
    bit_idx_d   = bit_idx_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d     = win0 ? req0_data : req1_data;
          last_data_d = win0 ? req0_data : req1_data;
          grant_d     = win1;
          ptr_d       = win1;
          bit_idx_d   = 3'd7;
          state_d     = SHIFT_LO;
        end else if (refresh_fire) begin
          shift_d   = last_data_q;
          bit_idx_d = 3'd7;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (cnt_done) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (cnt_done) begin
          if (bit_idx_q == 3'd0) begin
            state_d = LATCH;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q - 3'd1;
            state_d   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (cnt_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cnt_d = ((state_d != state_q) || is_idle) ? 16'd0 : cnt_q + 16'd1;

    // Pin values are derived from the next state so every pin comes straight from a flop.
    busy_d       = (state_d != IDLE);
    ser_clk_d    = (state_d == SHIFT_HI);
    ser_latch_d  = (state_d == LATCH);
    frame_done_d = (state_d == DONE);
    ser_data_d   = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) & shift_d[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      last_data_q  <= '0;
      bit_idx_q    <= '0;
      ptr_q        <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      ser_data_q   <= 1'b0;
      ser_clk_q    <= 1'b0;
      ser_latch_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      last_data_q  <= last_data_d;
      bit_idx_q    <= bit_idx_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      ser_data_q   <= ser_data_d;
      ser_clk_q    <= ser_clk_d;
      ser_latch_q  <= ser_latch_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign ser_data   = ser_data_q;
  assign ser_clk    = ser_clk_q;
  assign ser_latch  = ser_latch_q;
  assign frame_done = frame_done_q;

endmodule
